// File: rtl/ca_nco_generator_if.sv
// Bus bundle for the NCO-paced GPS C/A code generator.
// Build option: define EARLY_LATE_EN to add the early/late chip outputs.
interface ca_nco_generator_if #(
    parameter int NCO_WIDTH = 32
);
    logic                 enable;
    logic [4:0]           prn;
    logic [NCO_WIDTH-1:0] rate_inc;
    logic                 load;
    logic [9:0]           load_phase;
    logic [9:0]           code_shift;
    logic                 out;
    logic                 chip_strobe;
    logic                 epoch;
    logic                 busy;
    logic [9:0]           g1;
`ifdef EARLY_LATE_EN
    logic                 early;
    logic                 late;

    modport master (
        output enable, prn, rate_inc, load, load_phase,
        input  code_shift, out, chip_strobe, epoch, busy, g1, early, late
    );
    modport slave (
        input  enable, prn, rate_inc, load, load_phase,
        output code_shift, out, chip_strobe, epoch, busy, g1, early, late
    );
`else
    modport master (
        output enable, prn, rate_inc, load, load_phase,
        input  code_shift, out, chip_strobe, epoch, busy, g1
    );
    modport slave (
        input  enable, prn, rate_inc, load, load_phase,
        output code_shift, out, chip_strobe, epoch, busy, g1
    );
`endif
endinterface

// File: rtl/ca_nco_generator.sv
// GPS L1 C/A Gold-code generator paced by a phase-accumulator NCO, with code-phase slew.
// Build option: define EARLY_LATE_EN to add half-chip early/late outputs.
module ca_nco_generator #(
    parameter int NCO_WIDTH = 32,
    parameter int CODE_LEN  = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    ca_nco_generator_if.slave    bus
);
    typedef enum logic {RUN, SLEW} state_t;

    localparam logic [9:0] LAST = 10'(CODE_LEN - 1);

    // Register bit k holds LFSR stage k+1, so stage 10 is bit 9.
    function automatic logic [9:0] g1_step(input logic [9:0] s);
        return {s[8:0], s[2] ^ s[9]};
    endfunction

    function automatic logic [9:0] g2_step(input logic [9:0] s);
        return {s[8:0], s[1] ^ s[2] ^ s[5] ^ s[7] ^ s[8] ^ s[9]};
    endfunction

    function automatic logic [7:0] taps(input logic [4:0] p);
        case (p)
            5'd0:    taps = {4'd2, 4'd6};
            5'd1:    taps = {4'd3, 4'd7};
            5'd2:    taps = {4'd4, 4'd8};
            5'd3:    taps = {4'd5, 4'd9};
            5'd4:    taps = {4'd1, 4'd9};
            5'd5:    taps = {4'd2, 4'd10};
            5'd6:    taps = {4'd1, 4'd8};
            5'd7:    taps = {4'd2, 4'd9};
            5'd8:    taps = {4'd3, 4'd10};
            5'd9:    taps = {4'd2, 4'd3};
            5'd10:   taps = {4'd3, 4'd4};
            5'd11:   taps = {4'd5, 4'd6};
            5'd12:   taps = {4'd6, 4'd7};
            5'd13:   taps = {4'd7, 4'd8};
            5'd14:   taps = {4'd8, 4'd9};
            5'd15:   taps = {4'd9, 4'd10};
            5'd16:   taps = {4'd1, 4'd4};
            5'd17:   taps = {4'd2, 4'd5};
            5'd18:   taps = {4'd3, 4'd6};
            5'd19:   taps = {4'd4, 4'd7};
            5'd20:   taps = {4'd5, 4'd8};
            5'd21:   taps = {4'd6, 4'd9};
            5'd22:   taps = {4'd1, 4'd3};
            5'd23:   taps = {4'd4, 4'd6};
            5'd24:   taps = {4'd5, 4'd7};
            5'd25:   taps = {4'd6, 4'd8};
            5'd26:   taps = {4'd7, 4'd9};
            5'd27:   taps = {4'd8, 4'd10};
            5'd28:   taps = {4'd1, 4'd6};
            5'd29:   taps = {4'd2, 4'd7};
            5'd30:   taps = {4'd3, 4'd8};
            default: taps = {4'd4, 4'd9};
        endcase
    endfunction

    function automatic logic chip_of(input logic [9:0] g1s, input logic [9:0] g2s,
                                     input logic [4:0] p);
        logic [7:0] t;
        t = taps(p);
        return g1s[9] ^ g2s[t[7:4] - 4'd1] ^ g2s[t[3:0] - 4'd1];
    endfunction

    state_t               state_q, state_d;
    logic [NCO_WIDTH-1:0] acc_q, acc_d;
    logic [NCO_WIDTH:0]   sum;
    logic [9:0]           g1_q, g1_d, g2_q, g2_d;
    logic [9:0]           code_shift_q, code_shift_d;
    logic [9:0]           target_q, target_d;
    logic [4:0]           prn_q, prn_d;
    logic                 strobe_q, strobe_d;
    logic                 epoch_q, epoch_d;
    logic                 advance;
    logic                 out_chip;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        g1_d         = g1_q;
        g2_d         = g2_q;
        code_shift_d = code_shift_q;
        target_d     = target_q;
        prn_d        = prn_q;
        strobe_d     = 1'b0;
        epoch_d      = 1'b0;
        advance      = 1'b0;
        sum          = {1'b0, acc_q} + {1'b0, bus.rate_inc};

        if (bus.load) begin
            prn_d        = bus.prn;
            target_d     = (bus.load_phase >= 10'(CODE_LEN)) ? 10'd0 : bus.load_phase;
            acc_d        = '0;
            code_shift_d = 10'd0;
            g1_d         = 10'h3FF;
            g2_d         = 10'h3FF;
            state_d      = SLEW;
        end else if (state_q == SLEW) begin
            if (code_shift_q == target_q) begin
                state_d = RUN;
            end else begin
                advance = 1'b1;
            end
        end else if (bus.enable) begin
            acc_d    = sum[NCO_WIDTH-1:0];
            advance  = sum[NCO_WIDTH];
            strobe_d = sum[NCO_WIDTH];
            epoch_d  = sum[NCO_WIDTH] && (code_shift_q == LAST);
        end

        // The epoch wrap reloads the LFSRs rather than stepping them.
        if (advance) begin
            if (code_shift_q == LAST) begin
                g1_d         = 10'h3FF;
                g2_d         = 10'h3FF;
                code_shift_d = 10'd0;
            end else begin
                g1_d         = g1_step(g1_q);
                g2_d         = g2_step(g2_q);
                code_shift_d = code_shift_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            acc_q        <= '0;
            g1_q         <= 10'h3FF;
            g2_q         <= 10'h3FF;
            code_shift_q <= 10'd0;
            target_q     <= 10'd0;
            prn_q        <= bus.prn;
            strobe_q     <= 1'b0;
            epoch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            g1_q         <= g1_d;
            g2_q         <= g2_d;
            code_shift_q <= code_shift_d;
            target_q     <= target_d;
            prn_q        <= prn_d;
            strobe_q     <= strobe_d;
            epoch_q      <= epoch_d;
        end
    end

    assign out_chip        = chip_of(g1_q, g2_q, prn_q);
    assign bus.out         = out_chip;
    assign bus.code_shift  = code_shift_q;
    assign bus.chip_strobe = strobe_q;
    assign bus.epoch       = epoch_q;
    assign bus.busy        = (state_q == SLEW);
    assign bus.g1          = g1_q;

`ifdef EARLY_LATE_EN
    logic       next_chip_q, next_chip_d;
    logic       prev_chip_q, prev_chip_d;
    logic [9:0] look_g1, look_g2;

    // next_chip is the chip that follows whatever the LFSRs will hold after this edge.
    always_comb begin
        look_g1     = g1_step(g1_d);
        look_g2     = g2_step(g2_d);
        prev_chip_d = prev_chip_q;
        if (code_shift_d == LAST) begin
            look_g1 = 10'h3FF;
            look_g2 = 10'h3FF;
        end
        next_chip_d = chip_of(look_g1, look_g2, prn_d);
        if (bus.load) begin
            prev_chip_d = 1'b1;
        end else if (advance) begin
            prev_chip_d = out_chip;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_chip_q <= chip_of(g1_step(10'h3FF), g2_step(10'h3FF), bus.prn);
            prev_chip_q <= 1'b1;
        end else begin
            next_chip_q <= next_chip_d;
            prev_chip_q <= prev_chip_d;
        end
    end

    assign bus.early = (state_q == SLEW || !acc_q[NCO_WIDTH-1]) ? out_chip : next_chip_q;
    assign bus.late  = (state_q == SLEW || acc_q[NCO_WIDTH-1]) ? out_chip : prev_chip_q;
`endif
endmodule

// File: tb/tb_ca_nco_generator.sv
// Self-checking bench for ca_nco_generator: directed scenarios plus randomized traffic
// compared every cycle against a sequence-level reference model.
module tb_ca_nco_generator;
    localparam int NW = 32;
    localparam logic [31:0] HALF    = 32'h8000_0000;
    localparam logic [31:0] QUARTER = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ca_nco_generator_if #(.NCO_WIDTH(NW)) bus ();

    ca_nco_generator #(.NCO_WIDTH(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int tap_a[32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap_b[32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    bit g1_seq[1023];
    bit g2_seq[1023];

    longint unsigned m_acc;
    int              m_idx;
    int              m_target;
    int              m_prn;
    bit              m_slew;
    bit              m_strobe;
    bit              m_epoch;
    bit              m_prev;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Chip n of a Gold code is G1(n) xor the two G2 phase-selector taps, which are
    // delayed copies of the G2 output sequence.
    function automatic bit gold_chip(input int p, input int idx);
        return g1_seq[idx] ^ g2_seq[(idx + 10 - tap_a[p]) % 1023]
                           ^ g2_seq[(idx + 10 - tap_b[p]) % 1023];
    endfunction

    function automatic logic [9:0] g1_state(input int idx);
        logic [9:0] s;
        for (int j = 1; j <= 10; j++) s[j-1] = g1_seq[(idx + 10 - j) % 1023];
        return s;
    endfunction

    task automatic model_step(input bit rst, input bit ld, input bit en, input logic [4:0] p,
                              input logic [31:0] inc, input logic [9:0] lp);
        longint unsigned total;
        bit carry;
        m_strobe = 1'b0;
        m_epoch  = 1'b0;
        if (rst) begin
            m_acc = 0; m_idx = 0; m_slew = 1'b0; m_prn = int'(p); m_prev = 1'b1;
        end else if (ld) begin
            m_prn = int'(p); m_target = (int'(lp) >= 1023) ? 0 : int'(lp);
            m_acc = 0; m_idx = 0; m_slew = 1'b1; m_prev = 1'b1;
        end else if (m_slew) begin
            if (m_idx == m_target) m_slew = 1'b0;
            else begin
                m_prev = gold_chip(m_prn, m_idx);
                m_idx  = m_idx + 1;
            end
        end else if (en) begin
            total    = m_acc + longint'(inc);
            carry    = (total >= 64'h1_0000_0000);
            m_acc    = total & 64'hFFFF_FFFF;
            m_strobe = carry;
            m_epoch  = carry && (m_idx == 1022);
            if (carry) begin
                m_prev = gold_chip(m_prn, m_idx);
                m_idx  = (m_idx + 1) % 1023;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ld, input bit en, input logic [4:0] p,
                                 input logic [31:0] inc, input logic [9:0] lp);
        bit exp_out;
        reset          = rst;
        bus.load       = ld;
        bus.enable     = en;
        bus.prn        = p;
        bus.rate_inc   = inc;
        bus.load_phase = lp;
        @(posedge clk);
        model_step(rst, ld, en, p, inc, lp);
        @(negedge clk);
        exp_out = gold_chip(m_prn, m_idx);
        checkOutput("code_shift", 32'(bus.code_shift), m_idx);
        checkOutput("out", 32'(bus.out), 32'(exp_out));
        checkOutput("chip_strobe", 32'(bus.chip_strobe), 32'(m_strobe));
        checkOutput("epoch", 32'(bus.epoch), 32'(m_epoch));
        checkOutput("busy", 32'(bus.busy), 32'(m_slew));
        checkOutput("g1", 32'(bus.g1), 32'(g1_state(m_idx)));
`ifdef EARLY_LATE_EN
        if (m_slew) begin
            checkOutput("early", 32'(bus.early), 32'(exp_out));
            checkOutput("late", 32'(bus.late), 32'(exp_out));
        end else begin
            checkOutput("early", 32'(bus.early),
                        32'(m_acc[31] ? gold_chip(m_prn, (m_idx + 1) % 1023) : exp_out));
            checkOutput("late", 32'(bus.late), 32'(m_acc[31] ? exp_out : m_prev));
        end
`endif
    endtask

    task automatic run_cycles(input int n, input bit en, input logic [31:0] inc);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, en, 5'd0, inc, 10'd0);
    endtask

    task automatic collect_chips(input logic [31:0] inc, output logic [9:0] v, output int cycles);
        int n;
        v      = '0;
        v[9]   = bus.out;
        n      = 1;
        cycles = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, inc, 10'd0);
            cycles++;
            if (bus.chip_strobe) begin
                v[9-n] = bus.out;
                n++;
            end
        end
    endtask

    task automatic wait_epoch(output int cnt);
        cnt = -1;
        for (int c = 1; c <= 3000; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, HALF, 10'd0);
            if (bus.epoch) begin
                cnt = c;
                break;
            end
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int c = 0; c < 2000 && bus.busy; c++) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, HALF, 10'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0]  chips;
        logic [9:0]  saved_shift;
        logic [31:0] inc;
        int          cnt, cycles, strobes, r;

        for (int n = 0; n < 1023; n++) begin
            if (n < 10) begin
                g1_seq[n] = 1'b1;
                g2_seq[n] = 1'b1;
            end else begin
                g1_seq[n] = g1_seq[n-3] ^ g1_seq[n-10];
                g2_seq[n] = g2_seq[n-2] ^ g2_seq[n-3] ^ g2_seq[n-6] ^ g2_seq[n-8]
                          ^ g2_seq[n-9] ^ g2_seq[n-10];
            end
        end

        // Reset values, then the first ten chips of PRN1 and PRN2.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, HALF, 10'd0);
        checkOutput("reset_g1", 32'(bus.g1), 32'h3FF);
        checkOutput("reset_out", 32'(bus.out), 32'd1);
        collect_chips(HALF, chips, cycles);
        checkOutput("prn1_chips", 32'(chips), 32'h320);
        checkOutput("prn1_strobe_spacing", cycles, 32'd18);

        applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, HALF, 10'd0);
        collect_chips(HALF, chips, cycles);
        checkOutput("prn2_chips", 32'(chips), 32'h390);

        // Epoch timing: 1023 chips at two clocks per chip.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, HALF, 10'd0);
        wait_epoch(cnt);
        checkOutput("epoch_from_reset", cnt, 32'd2046);
        checkOutput("epoch_code_shift", 32'(bus.code_shift), 32'd0);
        checkOutput("epoch_g1", 32'(bus.g1), 32'h3FF);
        checkOutput("epoch_strobe", 32'(bus.chip_strobe), 32'd1);
        wait_epoch(cnt);
        checkOutput("epoch_period", cnt, 32'd2046);

        // Slew to chip 5 of PRN1, then the out-of-range phase.
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd0, HALF, 10'd5);
        count_busy(cnt);
        checkOutput("load5_busy_cycles", cnt, 32'd6);
        checkOutput("load5_code_shift", 32'(bus.code_shift), 32'd5);
        checkOutput("load5_out", 32'(bus.out), 32'(gold_chip(0, 5)));
        run_cycles(20, 1'b1, HALF);
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd0, HALF, 10'd1023);
        count_busy(cnt);
        checkOutput("load1023_busy_cycles", cnt, 32'd1);
        checkOutput("load1023_code_shift", 32'(bus.code_shift), 32'd0);

        // Reset aborts a long slew.
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd3, HALF, 10'd500);
        run_cycles(100, 1'b1, HALF);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, HALF, 10'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_code_shift", 32'(bus.code_shift), 32'd0);
        checkOutput("abort_g1", 32'(bus.g1), 32'h3FF);

        // Enable low freezes the code.
        run_cycles(7, 1'b1, HALF);
        saved_shift = bus.code_shift;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, HALF, 10'd0);
            strobes += int'(bus.chip_strobe);
        end
        checkOutput("hold_strobes", strobes, 32'd0);
        checkOutput("hold_code_shift", 32'(bus.code_shift), 32'(saved_shift));

        // Randomized traffic against the model.
        inc = HALF;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 4))
                    0:       inc = $urandom;
                    1:       inc = 32'd0;
                    2:       inc = HALF;
                    3:       inc = 32'hFFFF_FFFF;
                    default: inc = 32'h1000_0000 + ($urandom & 32'h0FFF_FFFF);
                endcase
            end
            r = $urandom_range(0, 99);
            applyStimulus(r == 0, r >= 1 && r <= 3, $urandom_range(0, 7) != 0, 5'($urandom),
                          inc, ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                           : 10'($urandom_range(0, 40)));
        end

`ifdef EARLY_LATE_EN
        // Four clocks per chip over a whole epoch exercises early/late spacing.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'($urandom), QUARTER, 10'd0);
        run_cycles(4100, 1'b1, QUARTER);
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd7, QUARTER, 10'd30);
        run_cycles(200, 1'b1, QUARTER);
`else
        applyStimulus(1'b1, 1'b0, 1'b1, 5'($urandom), QUARTER, 10'd0);
        run_cycles(100, 1'b1, QUARTER);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
